// File: rtl/pipe_stage_queue.sv
// pipe_stage_queue: circular-buffer pipeline stage (e.g. IF/ID) with
// stall back-pressure, branch flush, flush hold-off and flush_done pulse.
// Synchronous active-high reset has priority over flush, push and pop.
module pipe_stage_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              flush_hold,
  output logic [CNT_W-1:0]  count,
  output logic              flush_done
);

  // A 1-entry buffer still needs a 1-bit pointer so the storage index is legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              flush_done_r;

  logic              eff_flush_s;
  logic              push_s;
  logic              pop_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic [DATA_W-1:0] out_data_s;

  // Pointer advance that wraps at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_next = {PTR_W{1'b0}};
    end else begin
      ptr_next = p + PTR_W'(1);
    end
  endfunction

  // Handshake qualification: hold cancels flush, an effective flush kills push/pop.
  always_comb begin
    eff_flush_s = flush & ~flush_hold;
    in_ready_s  = (count_r < CNT_W'(DEPTH));
    out_valid_s = (count_r != {CNT_W{1'b0}});
    push_s      = in_valid & in_ready_s & ~eff_flush_s;
    pop_s       = out_valid_s & out_ready & ~eff_flush_s;
  end

  // Head payload, masked to an all-zero bubble when the queue is empty.
  always_comb begin
    out_data_s = {DATA_W{1'b0}};
    if (out_valid_s) begin
      out_data_s = mem_r[rd_ptr_r];
    end else begin
      out_data_s = {DATA_W{1'b0}};
    end
  end

  // Pointer and occupancy state; reset first, then flush, then push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (eff_flush_s) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are left stale on flush/reset since out_data is masked.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // One-cycle pulse following every effective flush, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_done_r <= 1'b0;
    end else begin
      flush_done_r <= eff_flush_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign out_data   = out_data_s;
  assign count      = count_r;
  assign flush_done = flush_done_r;

endmodule

// File: tb/tb_pipe_stage_queue.sv
// Self-checking bench for pipe_stage_queue: DEPTH=2 and DEPTH=3 instances,
// scoreboard queue of expected entries, directed cases plus random traffic.
module tb_pipe_stage_queue;

  logic clock;
  int   n_checks;
  int   n_errors;

  // DEPTH=2 instance signals
  logic        reset2, in_valid2, out_ready2, flush2, flush_hold2;
  logic [63:0] in_data2;
  logic        in_ready2, out_valid2, flush_done2;
  logic [63:0] out_data2;
  logic [1:0]  count2;

  // DEPTH=3 instance signals
  logic        reset3, in_valid3, out_ready3, flush3, flush_hold3;
  logic [63:0] in_data3;
  logic        in_ready3, out_valid3, flush_done3;
  logic [63:0] out_data3;
  logic [1:0]  count3;

  // Scoreboard: expected buffered entries, head at index 0.
  logic [63:0] sb_q[$];
  logic        exp_fd;

  pipe_stage_queue #(.DATA_W(64), .DEPTH(2)) dut2 (
    .clock(clock), .reset(reset2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .flush(flush2), .flush_hold(flush_hold2),
    .count(count2), .flush_done(flush_done2)
  );

  pipe_stage_queue #(.DATA_W(64), .DEPTH(3)) dut3 (
    .clock(clock), .reset(reset3),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .flush(flush3), .flush_hold(flush_hold3),
    .count(count3), .flush_done(flush_done3)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle on the selected DUT: drive, update the model, clock, compare.
  task automatic step(input int dut, input logic rst, input logic iv, input logic [63:0] d,
                      input logic ordy, input logic fl, input logic fh);
    int          depth;
    logic        eff, do_pop, do_push;
    logic [63:0] head;
    logic [63:0] a_od;
    logic        a_ov, a_ir, a_fd;
    logic [1:0]  a_cnt;
    depth = (dut == 3) ? 3 : 2;
    if (dut == 3) begin
      reset3 = rst; in_valid3 = iv; in_data3 = d; out_ready3 = ordy; flush3 = fl; flush_hold3 = fh;
    end else begin
      reset2 = rst; in_valid2 = iv; in_data2 = d; out_ready2 = ordy; flush2 = fl; flush_hold2 = fh;
    end
    #1;
    eff = fl & ~fh;
    if (rst) begin
      sb_q.delete();
      exp_fd = 1'b0;
    end else begin
      do_pop  = (sb_q.size() != 0) && ordy && !eff;
      do_push = iv && (sb_q.size() < depth) && !eff;
      if (do_pop) begin
        head = sb_q.pop_front();
        a_od = (dut == 3) ? out_data3 : out_data2;
        check_eq($sformatf("d%0d_pop_data", dut), a_od, head);
      end
      if (do_push) sb_q.push_back(d);
      if (eff) sb_q.delete();
      exp_fd = eff;
    end
    @(posedge clock);
    #1;
    if (dut == 3) begin
      a_od = out_data3; a_ov = out_valid3; a_ir = in_ready3; a_fd = flush_done3; a_cnt = count3;
    end else begin
      a_od = out_data2; a_ov = out_valid2; a_ir = in_ready2; a_fd = flush_done2; a_cnt = count2;
    end
    check_eq($sformatf("d%0d_count", dut), 64'(a_cnt), 64'(sb_q.size()));
    check_eq($sformatf("d%0d_out_valid", dut), 64'(a_ov), 64'(sb_q.size() != 0));
    check_eq($sformatf("d%0d_out_data", dut), a_od, (sb_q.size() != 0) ? sb_q[0] : 64'h0);
    check_eq($sformatf("d%0d_in_ready", dut), 64'(a_ir), 64'(sb_q.size() < depth));
    check_eq($sformatf("d%0d_flush_done", dut), 64'(a_fd), 64'(exp_fd));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_fd   = 1'b0;
    reset2 = 1'b1; in_valid2 = 1'b0; in_data2 = 64'h0; out_ready2 = 1'b0; flush2 = 1'b0; flush_hold2 = 1'b0;
    reset3 = 1'b1; in_valid3 = 1'b0; in_data3 = 64'h0; out_ready3 = 1'b0; flush3 = 1'b0; flush_hold3 = 1'b0;

    // ---------------- DEPTH=2 ----------------
    step(2, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 64'h55, 1'b1, 1'b1, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // In-order delivery under stall, then drain
    step(2, 1'b0, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 64'hD, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Simultaneous push and pop at count=1
    step(2, 1'b0, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Effective flush of a full queue with a same-cycle push
    step(2, 1'b0, 1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 64'h33, 1'b1, 1'b1, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Held flush is ignored and not remembered
    step(2, 1'b0, 1'b1, 64'h44, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
    step(2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 64'h66, 1'b1, 1'b1, 1'b1);
    step(2, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush of an empty queue still pulses flush_done
    step(2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Reset beats flush and push on a full queue
    step(2, 1'b0, 1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 64'h88, 1'b0, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 64'h99, 1'b0, 1'b1, 1'b0);
    step(2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(2, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
    end
    in_valid2 = 1'b0; flush2 = 1'b0; flush_hold2 = 1'b0; out_ready2 = 1'b0;

    // ---------------- DEPTH=3 ----------------
    step(3, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(3, 1'b0, 1'b1, 64'h100 + 64'(i), (i % 3 == 2), 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      step(3, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      step(3, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
